irq_scheduler: RTL and testbench

IRQ_SCHEDULER -- requirements
Module: irq_scheduler

---
 rtl/irq_scheduler_pkg.sv | 13 +
 rtl/irq_prio_sel.sv | 24 ++
 rtl/irq_scheduler.sv | 127 ++++++++++++
 tb/tb_irq_scheduler.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/irq_scheduler_pkg.sv
// Shared types and default sizing for the interrupt scheduler.
package irq_scheduler_pkg;

  localparam int unsigned NR_SRC_DEF   = 8;
  localparam int unsigned SEL_BITS_DEF = 3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_t;

endpackage

// File: rtl/irq_prio_sel.sv
// Combinational highest-index-set encoder: id of the top set bit, valid if any bit set.
module irq_prio_sel
  import irq_scheduler_pkg::*;
#(
  parameter int unsigned N = NR_SRC_DEF,
  parameter int unsigned W = SEL_BITS_DEF
) (
  input  logic [N-1:0] req,
  output logic [W-1:0] id,
  output logic         valid
);

  always_comb begin
    id    = '0;
    valid = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (req[i]) begin
        id    = W'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/irq_scheduler.sv
// Nested, edge-triggered interrupt scheduler with highest-index priority.
// Optional mask register enabled by defining IRQ_SCHED_MASK_EN.
module irq_scheduler
  import irq_scheduler_pkg::*;
#(
  parameter int unsigned NR_SRC   = NR_SRC_DEF,
  parameter int unsigned SEL_BITS = SEL_BITS_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NR_SRC-1:0]   irq_src,
  input  logic                int_ack,
  input  logic                eret,
`ifdef IRQ_SCHED_MASK_EN
  input  logic                mask_we,
  input  logic [NR_SRC-1:0]   mask_wdata,
`endif
  output logic                int_req,
  output logic [SEL_BITS-1:0] int_id,
  output logic [NR_SRC-1:0]   pending,
  output logic [NR_SRC-1:0]   in_service
);

  state_t              state, state_n;
  logic [NR_SRC-1:0]   src_q, src_edge, mask, above, elig, isv_eff, top_isv, ack_mask;
  logic                armed, win_valid, isv_valid, load_id, take_ack;
  logic [SEL_BITS-1:0] id_q, win_id, isv_id;

`ifdef IRQ_SCHED_MASK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       mask <= '0;
    else if (mask_we) mask <= mask_wdata;
  end
`else
  assign mask = '0;
`endif

  // The first cycle after reset only primes the history, so lines already high are not edges.
  assign src_edge = armed ? (irq_src & ~src_q) : '0;

  irq_prio_sel #(.N(NR_SRC), .W(SEL_BITS)) u_isv_sel (
    .req   (in_service),
    .id    (isv_id),
    .valid (isv_valid)
  );

  // Eligibility sees in_service with this cycle's eret already applied.
  always_comb begin
    top_isv = '0;
    if (eret && isv_valid && state != IDLE) top_isv[isv_id] = 1'b1;
    isv_eff = in_service & ~top_isv;
  end

  always_comb begin
    logic seen;
    seen  = 1'b0;
    above = '0;
    for (int unsigned k = 0; k < NR_SRC; k++) begin
      seen                 = seen | isv_eff[NR_SRC-1-k];
      above[NR_SRC-1-k]    = ~seen;
    end
  end

  assign elig = pending & ~mask & above;

  irq_prio_sel #(.N(NR_SRC), .W(SEL_BITS)) u_win_sel (
    .req   (elig),
    .id    (win_id),
    .valid (win_valid)
  );

  always_comb begin
    state_n  = state;
    load_id  = 1'b0;
    take_ack = 1'b0;
    unique case (state)
      IDLE: begin
        if (win_valid) begin
          state_n = REQ;
          load_id = 1'b1;
        end
      end
      REQ: begin
        if (int_ack) begin
          state_n  = SERVICE;
          take_ack = 1'b1;
        end
      end
      SERVICE: begin
        if (win_valid) begin
          state_n = REQ;
          load_id = 1'b1;
        end else if (isv_eff == '0) begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    ack_mask = '0;
    if (take_ack) ack_mask[id_q] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      id_q       <= '0;
      src_q      <= '0;
      armed      <= 1'b0;
      pending    <= '0;
      in_service <= '0;
    end else begin
      state      <= state_n;
      src_q      <= irq_src;
      armed      <= 1'b1;
      pending    <= (pending & ~ack_mask) | src_edge;
      in_service <= isv_eff | ack_mask;
      if (load_id) id_q <= win_id;
    end
  end

  assign int_req = (state == REQ);
  assign int_id  = int_req ? id_q : '0;

endmodule

// File: tb/tb_irq_scheduler.sv
// Directed-vector bench for irq_scheduler (default 8 sources).
module tb_irq_scheduler;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] irq_src;
  logic       int_ack, eret;
  logic       int_req;
  logic [2:0] int_id;
  logic [7:0] pending, in_service;
`ifdef IRQ_SCHED_MASK_EN
  logic       mask_we;
  logic [7:0] mask_wdata;
`endif

  int vecs = 0;
  int errs = 0;

  irq_scheduler #(.NR_SRC(8), .SEL_BITS(3)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .irq_src    (irq_src),
    .int_ack    (int_ack),
    .eret       (eret),
`ifdef IRQ_SCHED_MASK_EN
    .mask_we    (mask_we),
    .mask_wdata (mask_wdata),
`endif
    .int_req    (int_req),
    .int_id     (int_id),
    .pending    (pending),
    .in_service (in_service)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    irq_src = '0;
    int_ack = 1'b0;
    eret    = 1'b0;
`ifdef IRQ_SCHED_MASK_EN
    mask_we    = 1'b0;
    mask_wdata = '0;
`endif
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; irq_src = '0; int_ack = 1'b0; eret = 1'b0;
`ifdef IRQ_SCHED_MASK_EN
    mask_we = 1'b0; mask_wdata = '0;
`endif
    #2;
    vecs++; if (int_req !== 1'b0) begin errs++; $display("FAIL rst_req: got %b want 0", int_req); end
    vecs++; if (int_id !== 3'd0) begin errs++; $display("FAIL rst_id: got %0d want 0", int_id); end
    vecs++; if (pending !== 8'h00) begin errs++; $display("FAIL rst_pend: got %h want 00", pending); end
    vecs++; if (in_service !== 8'h00) begin errs++; $display("FAIL rst_isv: got %h want 00", in_service); end
    tick(); rst_n = 1'b1; tick();
  endtask

  task automatic test_single();
    do_reset();
    repeat (7) tick();
    irq_src = 8'h08; tick();
    vecs++; if (pending !== 8'h08) begin errs++; $display("FAIL single_pend: got %h want 08", pending); end
    vecs++; if (int_req !== 1'b0) begin errs++; $display("FAIL single_req_early: got %b want 0", int_req); end
    tick();
    vecs++; if (int_req !== 1'b1) begin errs++; $display("FAIL single_req: got %b want 1", int_req); end
    vecs++; if (int_id !== 3'd3) begin errs++; $display("FAIL single_id: got %0d want 3", int_id); end
    int_ack = 1'b1; tick(); int_ack = 1'b0;
    vecs++; if (in_service !== 8'h08) begin errs++; $display("FAIL single_isv: got %h want 08", in_service); end
    vecs++; if (pending !== 8'h00) begin errs++; $display("FAIL single_pend_clr: got %h want 00", pending); end
    vecs++; if (int_req !== 1'b0) begin errs++; $display("FAIL single_req_drop: got %b want 0", int_req); end
    eret = 1'b1; tick(); eret = 1'b0;
    vecs++; if (in_service !== 8'h00) begin errs++; $display("FAIL single_eret: got %h want 00", in_service); end
  endtask

  task automatic test_ack_ignored();
    do_reset();
    int_ack = 1'b1; eret = 1'b1; tick(); int_ack = 1'b0; eret = 1'b0; tick();
    vecs++; if (in_service !== 8'h00) begin errs++; $display("FAIL ign_isv: got %h want 00", in_service); end
    vecs++; if (int_req !== 1'b0) begin errs++; $display("FAIL ign_req: got %b want 0", int_req); end
  endtask

  task automatic test_priority();
    do_reset();
    irq_src = 8'h24; tick();
    vecs++; if (pending !== 8'h24) begin errs++; $display("FAIL prio_pend: got %h want 24", pending); end
    tick();
    vecs++; if (int_id !== 3'd5) begin errs++; $display("FAIL prio_id5: got %0d want 5", int_id); end
    int_ack = 1'b1; tick(); int_ack = 1'b0;
    vecs++; if (in_service !== 8'h20) begin errs++; $display("FAIL prio_isv: got %h want 20", in_service); end
    tick();
    vecs++; if (int_req !== 1'b0) begin errs++; $display("FAIL prio_blocked: got %b want 0", int_req); end
    vecs++; if (pending !== 8'h04) begin errs++; $display("FAIL prio_pend2: got %h want 04", pending); end
    eret = 1'b1; tick(); eret = 1'b0;
    vecs++; if (int_req !== 1'b1) begin errs++; $display("FAIL prio_req2: got %b want 1", int_req); end
    vecs++; if (int_id !== 3'd2) begin errs++; $display("FAIL prio_id2: got %0d want 2", int_id); end
    int_ack = 1'b1; tick(); int_ack = 1'b0;
    eret = 1'b1; tick(); eret = 1'b0;
    vecs++; if (in_service !== 8'h00) begin errs++; $display("FAIL prio_isv_end: got %h want 00", in_service); end
  endtask

  task automatic test_preempt();
    do_reset();
    irq_src = 8'h04; tick(); tick();
    int_ack = 1'b1; tick(); int_ack = 1'b0;
    vecs++; if (in_service !== 8'h04) begin errs++; $display("FAIL pre_isv2: got %h want 04", in_service); end
    irq_src = 8'h44; tick(); tick();
    vecs++; if (int_req !== 1'b1) begin errs++; $display("FAIL pre_req: got %b want 1", int_req); end
    vecs++; if (int_id !== 3'd6) begin errs++; $display("FAIL pre_id: got %0d want 6", int_id); end
    int_ack = 1'b1; tick(); int_ack = 1'b0;
    vecs++; if (in_service !== 8'h44) begin errs++; $display("FAIL pre_isv44: got %h want 44", in_service); end
    eret = 1'b1; tick(); eret = 1'b0;
    vecs++; if (in_service !== 8'h04) begin errs++; $display("FAIL pre_eret1: got %h want 04", in_service); end
    vecs++; if (int_req !== 1'b0) begin errs++; $display("FAIL pre_req_e1: got %b want 0", int_req); end
    eret = 1'b1; tick(); eret = 1'b0; tick();
    vecs++; if (in_service !== 8'h00) begin errs++; $display("FAIL pre_eret2: got %h want 00", in_service); end
    vecs++; if (int_req !== 1'b0) begin errs++; $display("FAIL pre_idle: got %b want 0", int_req); end
  endtask

  task automatic test_ack_edge_collide();
    do_reset();
    irq_src = 8'h10; tick(); tick();
    irq_src = 8'h00; tick();
    vecs++; if (int_id !== 3'd4) begin errs++; $display("FAIL col_id: got %0d want 4", int_id); end
    irq_src = 8'h10; int_ack = 1'b1; tick(); int_ack = 1'b0;
    vecs++; if (pending !== 8'h10) begin errs++; $display("FAIL col_pend: got %h want 10", pending); end
    vecs++; if (in_service !== 8'h10) begin errs++; $display("FAIL col_isv: got %h want 10", in_service); end
    vecs++; if (int_req !== 1'b0) begin errs++; $display("FAIL col_req: got %b want 0", int_req); end
    eret = 1'b1; tick(); eret = 1'b0;
    vecs++; if (int_req !== 1'b1) begin errs++; $display("FAIL col_rereq: got %b want 1", int_req); end
    vecs++; if (int_id !== 3'd4) begin errs++; $display("FAIL col_reid: got %0d want 4", int_id); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    irq_src = 8'h02; tick();
    irq_src = 8'h00; tick();
    vecs++; if (int_id !== 3'd1) begin errs++; $display("FAIL b2b_id: got %0d want 1", int_id); end
    irq_src = 8'h02; tick();
    vecs++; if (pending !== 8'h02) begin errs++; $display("FAIL b2b_absorb: got %h want 02", pending); end
    int_ack = 1'b1; tick(); int_ack = 1'b0;
    vecs++; if (pending !== 8'h00) begin errs++; $display("FAIL b2b_pend: got %h want 00", pending); end
    eret = 1'b1; tick(); eret = 1'b0; tick();
    vecs++; if (int_req !== 1'b0) begin errs++; $display("FAIL b2b_noreq: got %b want 0", int_req); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    irq_src = 8'h10; tick(); tick();
    int_ack = 1'b1; tick(); int_ack = 1'b0;
    irq_src = 8'h90; tick(); tick();
    vecs++; if (int_id !== 3'd7) begin errs++; $display("FAIL rmid_id: got %0d want 7", int_id); end
    vecs++; if (in_service !== 8'h10) begin errs++; $display("FAIL rmid_isv: got %h want 10", in_service); end
    rst_n = 1'b0; #1;
    vecs++; if (int_req !== 1'b0) begin errs++; $display("FAIL rmid_req: got %b want 0", int_req); end
    vecs++; if (pending !== 8'h00) begin errs++; $display("FAIL rmid_pend: got %h want 00", pending); end
    vecs++; if (in_service !== 8'h00) begin errs++; $display("FAIL rmid_isv0: got %h want 00", in_service); end
    tick(); rst_n = 1'b1; tick(); tick(); tick();
    vecs++; if (pending !== 8'h00) begin errs++; $display("FAIL rmid_noedge: got %h want 00", pending); end
    vecs++; if (int_req !== 1'b0) begin errs++; $display("FAIL rmid_noreq: got %b want 0", int_req); end
    irq_src = 8'h00;
  endtask

`ifdef IRQ_SCHED_MASK_EN
  task automatic test_mask();
    do_reset();
    mask_wdata = 8'h80; mask_we = 1'b1; tick(); mask_we = 1'b0;
    irq_src = 8'h80; tick(); tick();
    vecs++; if (pending !== 8'h80) begin errs++; $display("FAIL mask_pend: got %h want 80", pending); end
    vecs++; if (int_req !== 1'b0) begin errs++; $display("FAIL mask_req: got %b want 0", int_req); end
    mask_wdata = 8'h00; mask_we = 1'b1; tick(); mask_we = 1'b0; tick();
    vecs++; if (int_req !== 1'b1) begin errs++; $display("FAIL mask_open: got %b want 1", int_req); end
    vecs++; if (int_id !== 3'd7) begin errs++; $display("FAIL mask_id: got %0d want 7", int_id); end
    mask_wdata = 8'h80; mask_we = 1'b1; tick(); mask_we = 1'b0;
    vecs++; if (int_req !== 1'b1) begin errs++; $display("FAIL mask_hold: got %b want 1", int_req); end
  endtask
`endif

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_ack_ignored();
    test_priority();
    test_preempt();
    test_ack_edge_collide();
    test_back_to_back();
    test_reset_mid();
`ifdef IRQ_SCHED_MASK_EN
    test_mask();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
